// File: rtl/dpb_sched_pkg.sv
// rtl/dpb_sched_pkg.sv - shared types and constants for the DPB write-rank scheduler
package dpb_sched_pkg;

    typedef struct packed {
        logic       frame_down;
        logic [7:0] udp_rank;
        logic [3:0] buf_rank;
        logic [6:0] buf_128cnt;
        logic [5:0] buf_Bytecnt;
    } wr_desc_t;

    localparam int WR_DESC_W = $bits(wr_desc_t);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RETIRE = 2'd3
    } sched_state_t;

    localparam int ERR_FULL    = 0;
    localparam int ERR_TIMEOUT = 1;
    localparam int ERR_REUSE   = 2;
    localparam int ERR_STRAY   = 3;

endpackage

// File: rtl/dpb_desc_fifo.sv
// rtl/dpb_desc_fifo.sv - register-array show-ahead FIFO of write-rank descriptors
module dpb_desc_fifo
    import dpb_sched_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_pclk,
    input  logic                  i_rst_n,
    input  logic                  push_i,
    input  logic [WR_DESC_W-1:0]  push_data_i,
    input  logic                  pop_i,
    output logic [WR_DESC_W-1:0]  head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [WR_DESC_W-1:0]  mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full queue is dropped even if a pop happens in the same cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_pclk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/dpb_wr_rank_scheduler.sv
// rtl/dpb_wr_rank_scheduler.sv - queues DPB rank descriptors and issues them to the DDR3 write master
module dpb_wr_rank_scheduler
    import dpb_sched_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 4,
    parameter int          AFULL_LVL   = 12,
    parameter int unsigned TIMEOUT_CYC = 20'hFFFFF
) (
    input  logic                i_pclk,
    input  logic                i_rst_n,
    input  logic                i_wr_req,
    input  logic                i_wr_frame_down,
    input  logic [7:0]          i_wr_udp_rank,
    input  logic [3:0]          i_wr_buf_rank,
    input  logic [6:0]          i_wr_buf_128cnt,
    input  logic [5:0]          i_wr_buf_Bytecnt,
    output logic                o_ddr3_req,
    output logic                o_ddr3_frame_down,
    output logic [7:0]          o_ddr3_udp_rank,
    output logic [3:0]          o_ddr3_buf_rank,
    output logic [6:0]          o_ddr3_buf_128cnt,
    output logic [5:0]          o_ddr3_buf_Bytecnt,
    input  logic                i_ddr3_down,
    output logic [15:0]         o_rank_busy,
    output logic [DEPTH_LOG2:0] o_occupancy,
    output logic                o_almost_full,
    output logic [3:0]          o_error,
    input  logic                i_err_clr
);

    localparam int         CNT_W    = DEPTH_LOG2 + 1;
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYC - 1);

    wr_desc_t              push_desc;
    wr_desc_t              head_desc;
    logic [WR_DESC_W-1:0]  head_bits;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  push_ok;
    logic                  pop;
    logic                  tmo_hit;

    sched_state_t          state_q;
    logic                  req_q;
    wr_desc_t              out_q;
    logic [19:0]           timer_q;
    logic [15:0]           busy_q, busy_d;
    logic [3:0]            err_q, err_d;

    assign push_desc = '{frame_down:  i_wr_frame_down,
                         udp_rank:    i_wr_udp_rank,
                         buf_rank:    i_wr_buf_rank,
                         buf_128cnt:  i_wr_buf_128cnt,
                         buf_Bytecnt: i_wr_buf_Bytecnt};
    assign head_desc = wr_desc_t'(head_bits);
    assign push_ok   = i_wr_req & ~fifo_full;
    assign pop       = (state_q == S_RETIRE);
    // A down pulse arriving on the last allowed cycle counts as a normal completion.
    assign tmo_hit   = (state_q == S_WAIT) && !i_ddr3_down && (timer_q == TMO_LAST);

    dpb_desc_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_desc_fifo (
        .i_pclk      (i_pclk),
        .i_rst_n     (i_rst_n),
        .push_i      (i_wr_req),
        .push_data_i (push_desc),
        .pop_i       (pop),
        .head_o      (head_bits),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            out_q   <= '0;
            timer_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    out_q   <= head_desc;
                    req_q   <= 1'b1;
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    if (i_ddr3_down || timer_q == TMO_LAST) begin
                        req_q   <= 1'b0;
                        state_q <= S_RETIRE;
                    end
                end
                S_RETIRE: begin
                    req_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Clear before set so a rank re-pushed in the retire cycle stays marked busy.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_desc.buf_rank] = 1'b0;
        end
        if (push_ok) begin
            busy_d[i_wr_buf_rank] = 1'b1;
        end
    end

    always_comb begin
        err_d = i_err_clr ? 4'b0000 : err_q;
        if (i_wr_req && fifo_full) begin
            err_d[ERR_FULL] = 1'b1;
        end
        if (tmo_hit) begin
            err_d[ERR_TIMEOUT] = 1'b1;
        end
        if (push_ok && busy_q[i_wr_buf_rank]) begin
            err_d[ERR_REUSE] = 1'b1;
        end
        if (i_ddr3_down && state_q != S_WAIT) begin
            err_d[ERR_STRAY] = 1'b1;
        end
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= '0;
            err_q  <= '0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign o_ddr3_req         = req_q;
    assign o_ddr3_frame_down  = out_q.frame_down;
    assign o_ddr3_udp_rank    = out_q.udp_rank;
    assign o_ddr3_buf_rank    = out_q.buf_rank;
    assign o_ddr3_buf_128cnt  = out_q.buf_128cnt;
    assign o_ddr3_buf_Bytecnt = out_q.buf_Bytecnt;
    assign o_rank_busy        = busy_q;
    assign o_occupancy        = fifo_count;
    assign o_almost_full      = (fifo_count >= CNT_W'(AFULL_LVL));
    assign o_error            = err_q;

endmodule

// File: tb/tb_dpb_wr_rank_scheduler.sv
// tb/tb_dpb_wr_rank_scheduler.sv - directed self-checking bench for dpb_wr_rank_scheduler
module tb_dpb_wr_rank_scheduler;

    localparam int TMO = 16;

    logic        i_pclk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_wr_req = 1'b0;
    logic        i_wr_frame_down = 1'b0;
    logic [7:0]  i_wr_udp_rank = '0;
    logic [3:0]  i_wr_buf_rank = '0;
    logic [6:0]  i_wr_buf_128cnt = '0;
    logic [5:0]  i_wr_buf_Bytecnt = '0;
    logic        i_ddr3_down = 1'b0;
    logic        i_err_clr = 1'b0;
    logic        o_ddr3_req;
    logic        o_ddr3_frame_down;
    logic [7:0]  o_ddr3_udp_rank;
    logic [3:0]  o_ddr3_buf_rank;
    logic [6:0]  o_ddr3_buf_128cnt;
    logic [5:0]  o_ddr3_buf_Bytecnt;
    logic [15:0] o_rank_busy;
    logic [4:0]  o_occupancy;
    logic        o_almost_full;
    logic [3:0]  o_error;

    int checks = 0;
    int errors = 0;

    dpb_wr_rank_scheduler #(
        .DEPTH_LOG2  (4),
        .AFULL_LVL   (12),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .i_pclk             (i_pclk),
        .i_rst_n            (i_rst_n),
        .i_wr_req           (i_wr_req),
        .i_wr_frame_down    (i_wr_frame_down),
        .i_wr_udp_rank      (i_wr_udp_rank),
        .i_wr_buf_rank      (i_wr_buf_rank),
        .i_wr_buf_128cnt    (i_wr_buf_128cnt),
        .i_wr_buf_Bytecnt   (i_wr_buf_Bytecnt),
        .o_ddr3_req         (o_ddr3_req),
        .o_ddr3_frame_down  (o_ddr3_frame_down),
        .o_ddr3_udp_rank    (o_ddr3_udp_rank),
        .o_ddr3_buf_rank    (o_ddr3_buf_rank),
        .o_ddr3_buf_128cnt  (o_ddr3_buf_128cnt),
        .o_ddr3_buf_Bytecnt (o_ddr3_buf_Bytecnt),
        .i_ddr3_down        (i_ddr3_down),
        .o_rank_busy        (o_rank_busy),
        .o_occupancy        (o_occupancy),
        .o_almost_full      (o_almost_full),
        .o_error            (o_error),
        .i_err_clr          (i_err_clr)
    );

    always #5 i_pclk = ~i_pclk;

    task automatic tick();
        @(posedge i_pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic fd, input logic [7:0] udp, input logic [3:0] rank,
                        input logic [6:0] c128, input logic [5:0] bcnt);
        i_wr_req         = 1'b1;
        i_wr_frame_down  = fd;
        i_wr_udp_rank    = udp;
        i_wr_buf_rank    = rank;
        i_wr_buf_128cnt  = c128;
        i_wr_buf_Bytecnt = bcnt;
        tick();
        i_wr_req = 1'b0;
    endtask

    task automatic down_pulse();
        i_ddr3_down = 1'b1;
        tick();
        i_ddr3_down = 1'b0;
    endtask

    task automatic clr_pulse();
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int k;
        k = 0;
        while (!o_ddr3_req && k < 40) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, o_ddr3_req}, 32'd1);
    endtask

    task automatic serve(input string tag, input logic [7:0] udp, input logic [3:0] rank);
        wait_req({tag, "_req"});
        chk({tag, "_udp"}, {24'd0, o_ddr3_udp_rank}, {24'd0, udp});
        chk({tag, "_rank"}, {28'd0, o_ddr3_buf_rank}, {28'd0, rank});
        down_pulse();
        tick();
    endtask

    initial begin
        // reset state
        repeat (2) tick();
        chk("rst_req", {31'd0, o_ddr3_req}, 32'd0);
        chk("rst_occ", {27'd0, o_occupancy}, 32'd0);
        chk("rst_busy", {16'd0, o_rank_busy}, 32'd0);
        chk("rst_err", {28'd0, o_error}, 32'd0);
        chk("rst_af", {31'd0, o_almost_full}, 32'd0);
        i_rst_n = 1'b1;
        tick();

        // 1: single descriptor, N+3 latency, fields held, retire
        push(1'b0, 8'd1, 4'd3, 7'd91, 6'd5);
        chk("t1_occ", {27'd0, o_occupancy}, 32'd1);
        chk("t1_busy", {16'd0, o_rank_busy}, 32'h0008);
        tick();
        chk("t1_req_n2", {31'd0, o_ddr3_req}, 32'd0);
        tick();
        chk("t1_req_n3", {31'd0, o_ddr3_req}, 32'd1);
        chk("t1_udp", {24'd0, o_ddr3_udp_rank}, 32'd1);
        chk("t1_rank", {28'd0, o_ddr3_buf_rank}, 32'd3);
        chk("t1_128", {25'd0, o_ddr3_buf_128cnt}, 32'd91);
        chk("t1_bc", {26'd0, o_ddr3_buf_Bytecnt}, 32'd5);
        chk("t1_fd", {31'd0, o_ddr3_frame_down}, 32'd0);
        repeat (3) tick();
        chk("t1_hold_req", {31'd0, o_ddr3_req}, 32'd1);
        chk("t1_hold_128", {25'd0, o_ddr3_buf_128cnt}, 32'd91);
        down_pulse();
        tick();
        chk("t1_done_req", {31'd0, o_ddr3_req}, 32'd0);
        chk("t1_done_busy", {16'd0, o_rank_busy}, 32'd0);
        chk("t1_done_occ", {27'd0, o_occupancy}, 32'd0);

        // 2: five queued while down withheld, issued in order
        for (int i = 0; i < 5; i++) begin
            push(i == 4, 8'(10 + i), 4'(i), 7'(i + 1), 6'd0);
        end
        chk("t2_occ", {27'd0, o_occupancy}, 32'd5);
        chk("t2_busy", {16'd0, o_rank_busy}, 32'h001F);
        for (int i = 0; i < 4; i++) begin
            serve("t2", 8'(10 + i), 4'(i));
        end
        wait_req("t2_last_req");
        chk("t2_last_fd", {31'd0, o_ddr3_frame_down}, 32'd1);
        chk("t2_last_128", {25'd0, o_ddr3_buf_128cnt}, 32'd5);
        down_pulse();
        tick();
        chk("t2_end_busy", {16'd0, o_rank_busy}, 32'd0);
        chk("t2_end_occ", {27'd0, o_occupancy}, 32'd0);

        // 3: overflow and almost_full threshold
        for (int i = 0; i < 17; i++) begin
            push(1'b0, 8'(i), 4'(i), 7'd1, 6'd0);
            if (i == 10) begin
                chk("t3_occ11", {27'd0, o_occupancy}, 32'd11);
                chk("t3_af11", {31'd0, o_almost_full}, 32'd0);
            end
            if (i == 11) begin
                chk("t3_af12", {31'd0, o_almost_full}, 32'd1);
            end
        end
        chk("t3_occ", {27'd0, o_occupancy}, 32'd16);
        chk("t3_err_full", {31'd0, o_error[0]}, 32'd1);
        chk("t3_busy", {16'd0, o_rank_busy}, 32'hFFFF);
        for (int j = 0; j < 16; j++) begin
            serve("t3", 8'(j), 4'(j));
        end
        repeat (5) tick();
        chk("t3_no17_req", {31'd0, o_ddr3_req}, 32'd0);
        chk("t3_no17_occ", {27'd0, o_occupancy}, 32'd0);
        clr_pulse();
        chk("t3_clr", {28'd0, o_error}, 32'd0);

        // 4: rank reuse, stray down, clear vs new error in the same cycle
        push(1'b0, 8'h21, 4'd5, 7'd2, 6'd0);
        push(1'b0, 8'h22, 4'd5, 7'd3, 6'd0);
        chk("t4_reuse", {28'd0, o_error}, 32'h4);
        serve("t4a", 8'h21, 4'd5);
        serve("t4b", 8'h22, 4'd5);
        chk("t4_busy", {16'd0, o_rank_busy}, 32'd0);
        down_pulse();
        chk("t4_stray", {28'd0, o_error}, 32'hC);
        i_err_clr   = 1'b1;
        i_ddr3_down = 1'b1;
        tick();
        i_err_clr   = 1'b0;
        i_ddr3_down = 1'b0;
        chk("t4_clr_win", {28'd0, o_error}, 32'h8);
        clr_pulse();
        chk("t4_clr", {28'd0, o_error}, 32'd0);

        // push of the retiring rank in the retire cycle
        push(1'b0, 8'h30, 4'd7, 7'd1, 6'd0);
        wait_req("pp_req");
        down_pulse();
        push(1'b0, 8'h31, 4'd7, 7'd1, 6'd0);
        chk("pp_occ", {27'd0, o_occupancy}, 32'd1);
        chk("pp_busy", {16'd0, o_rank_busy}, 32'h0080);
        chk("pp_err", {28'd0, o_error}, 32'h4);
        serve("pp", 8'h31, 4'd7);
        chk("pp_busy_end", {16'd0, o_rank_busy}, 32'd0);
        clr_pulse();

        // 5: timeout boundary
        push(1'b0, 8'h40, 4'd8, 7'd1, 6'd0);
        push(1'b0, 8'h41, 4'd9, 7'd1, 6'd0);
        wait_req("t5_req");
        repeat (TMO - 1) tick();
        chk("t5_last_req", {31'd0, o_ddr3_req}, 32'd1);
        chk("t5_last_err", {28'd0, o_error}, 32'd0);
        tick();
        chk("t5_tmo_err", {28'd0, o_error}, 32'h2);
        chk("t5_tmo_req", {31'd0, o_ddr3_req}, 32'd0);
        tick();
        chk("t5_occ", {27'd0, o_occupancy}, 32'd1);
        chk("t5_busy", {16'd0, o_rank_busy}, 32'h0200);
        wait_req("t5_next_req");
        chk("t5_next_udp", {24'd0, o_ddr3_udp_rank}, 32'h41);
        clr_pulse();
        chk("t5_clr", {28'd0, o_error}, 32'd0);
        down_pulse();
        tick();

        // 6: asynchronous reset during WAIT
        push(1'b0, 8'h50, 4'd2, 7'd1, 6'd0);
        push(1'b0, 8'h51, 4'd2, 7'd1, 6'd0);
        wait_req("t6_req");
        chk("t6_pre_err", {28'd0, o_error}, 32'h4);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("t6_req", {31'd0, o_ddr3_req}, 32'd0);
        chk("t6_occ", {27'd0, o_occupancy}, 32'd0);
        chk("t6_busy", {16'd0, o_rank_busy}, 32'd0);
        chk("t6_err", {28'd0, o_error}, 32'd0);
        #1;
        i_rst_n = 1'b1;
        repeat (4) tick();
        chk("t6_idle_req", {31'd0, o_ddr3_req}, 32'd0);
        push(1'b0, 8'h60, 4'd1, 7'd1, 6'd0);
        serve("t6_after", 8'h60, 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
